// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types and constants for the shift-register sequencer: opcodes, FSM states
// and the core mode-select encoding.
package shift_seq_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_SHR  = 3'd2,
        OP_SHL  = 3'd3,
        OP_ROR  = 3'd4,
        OP_ROL  = 3'd5,
        OP_CLR  = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    // Ops whose step count comes from cmd_cnt.
    function automatic logic is_shift(input op_e op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) || (op == OP_ROL);
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Command channel into the sequencer.
// Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
// the master holds cmd_op/cmd_cnt/cmd_data stable while cmd_valid is high and not yet accepted.
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH) + 1
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic [WIDTH-1:0] cmd_data;

    modport master (output cmd_valid, cmd_op, cmd_cnt, cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_cnt, cmd_data, output cmd_ready);
endinterface

// File: rtl/shift_seq_ctrl_core.sv
// WIDTH-bit universal shift register: hold, shift right (ser_r into MSB),
// shift left (ser_l into LSB) or parallel load, selected per bit by mode.
module shift_reg_core
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             ser_r,
    input  logic             ser_l,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_nxt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic from_hi;
        logic from_lo;

        if (i == WIDTH - 1) begin : g_msb
            assign from_hi = ser_r;
        end else begin : g_mid_hi
            assign from_hi = q[i+1];
        end

        if (i == 0) begin : g_lsb
            assign from_lo = ser_l;
        end else begin : g_mid_lo
            assign from_lo = q[i-1];
        end

        assign q_nxt[i] = (mode == MODE_HOLD)  ? q[i]    :
                          (mode == MODE_RIGHT) ? from_hi :
                          (mode == MODE_LEFT)  ? from_lo : pin[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= q_nxt;
    end
endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer: latches one command, steps the shift core through it one
// update per cycle, then pulses done for a single cycle before accepting the next.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_seq_ctrl_if.slave  cmd,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state,
    output logic [1:0]       dbg_mode
);
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_EXEC = ST_EXEC;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]       state;
    op_e              op_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] data_r;
    logic [CNT_W-1:0] start_cnt;
    logic             accept;

    logic [1:0]       mode;
    logic             ser_r;
    logic             ser_l;
    logic [WIDTH-1:0] pin;

    assign cmd.cmd_ready = (state == S_IDLE);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign dbg_state     = state;
    assign dbg_mode      = mode;

    // A zero start count sends the command straight to DONE without touching q.
    always_comb begin
        start_cnt = '0;
        if (op_e'(cmd.cmd_op) == OP_LOAD || op_e'(cmd.cmd_op) == OP_CLR)
            start_cnt = CNT_W'(1);
        else if (is_shift(op_e'(cmd.cmd_op)))
            start_cnt = cmd.cmd_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_r   <= OP_NOP;
            cnt_r  <= '0;
            data_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_r   <= op_e'(cmd.cmd_op);
                        data_r <= cmd.cmd_data;
                        cnt_r  <= start_cnt;
                        state  <= (start_cnt == '0) ? S_DONE : S_EXEC;
                    end
                end
                S_EXEC: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Mode and serial routing depend only on state, latched op and q, so they
    // stay stable across the whole EXEC cycle.
    always_comb begin
        mode    = MODE_HOLD;
        pin     = data_r;
        ser_r   = 1'b0;
        ser_l   = 1'b0;
        ser_out = 1'b0;
        if (state == S_EXEC) begin
            case (op_r)
                OP_LOAD: mode = MODE_LOAD;
                OP_CLR: begin
                    mode = MODE_LOAD;
                    pin  = '0;
                end
                OP_SHR: begin
                    mode    = MODE_RIGHT;
                    ser_r   = ser_in;
                    ser_out = q[0];
                end
                OP_ROR: begin
                    mode    = MODE_RIGHT;
                    ser_r   = q[0];
                    ser_out = q[0];
                end
                OP_SHL: begin
                    mode    = MODE_LEFT;
                    ser_l   = ser_in;
                    ser_out = q[WIDTH-1];
                end
                OP_ROL: begin
                    mode    = MODE_LEFT;
                    ser_l   = q[WIDTH-1];
                    ser_out = q[WIDTH-1];
                end
                default: mode = MODE_HOLD;
            endcase
        end
    end

    shift_reg_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .ser_r (ser_r),
        .ser_l (ser_l),
        .pin   (pin),
        .q     (q)
    );
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: directed command table, held-valid and mid-command
// reset sequences, then random commands against a command-level model.
module tb_shift_seq_ctrl;
    import shift_seq_pkg::*;

    localparam int W  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ser_in = 1'b0;
    logic [W-1:0]  q;
    logic          ser_out, busy, done;
    logic [1:0]    dbg_state, dbg_mode;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] model_q;
    logic [W-1:0] exp_q[$];
    logic         exp_so[$];

    shift_seq_ctrl_if #(.WIDTH(W), .CNT_W(CW)) cmd_if ();

    shift_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd_if),
        .ser_in    (ser_in),
        .q         (q),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state),
        .dbg_mode  (dbg_mode)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] rot_r(input logic [W-1:0] v, input int k);
        int kk;
        int x;
        kk = k % W;
        x  = int'(v);
        if (kk == 0) return v;
        return W'((x >> kk) | (x << (W - kk)));
    endfunction

    function automatic logic [W-1:0] rot_l(input logic [W-1:0] v, input int k);
        return rot_r(v, W - (k % W));
    endfunction

    // ---------------- driver ----------------
    task automatic run_cmd(input logic [2:0] op, input logic [CW-1:0] cnt,
                           input logic [W-1:0] data, input logic [7:0] sbits);
        int          steps;
        int          guard;
        int          v;
        logic [1:0]  exp_mode;
        logic [W-1:0] q0, cur, nq;
        logic        so;

        steps    = 0;
        exp_mode = 2'b00;
        case (op)
            3'd1, 3'd6: begin steps = 1;        exp_mode = 2'b11; end
            3'd2, 3'd4: begin steps = int'(cnt); exp_mode = 2'b01; end
            3'd3, 3'd5: begin steps = int'(cnt); exp_mode = 2'b10; end
            default:    steps = 0;
        endcase

        q0  = model_q;
        cur = model_q;
        for (int i = 0; i < steps; i++) begin
            v  = int'(cur);
            nq = cur;
            so = 1'b0;
            case (op)
                3'd1: nq = data;
                3'd6: nq = '0;
                3'd2: begin so = cur[0];   nq = W'(v / 2 + int'(sbits[i]) * (1 << (W - 1))); end
                3'd3: begin so = cur[W-1]; nq = W'((v * 2) % (1 << W) + int'(sbits[i])); end
                3'd4: begin so = cur[0];   nq = rot_r(q0, i + 1); end
                3'd5: begin so = cur[W-1]; nq = rot_l(q0, i + 1); end
                default: nq = cur;
            endcase
            exp_q.push_back(nq);
            exp_so.push_back(so);
            cur = nq;
        end

        cmd_if.cmd_op    = op;
        cmd_if.cmd_cnt   = cnt;
        cmd_if.cmd_data  = data;
        cmd_if.cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_if.cmd_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!cmd_if.cmd_ready) begin
            check("handshake_timeout", 0, 1);
            cmd_if.cmd_valid = 1'b0;
            exp_q.delete();
            exp_so.delete();
            return;
        end
        tick();
        cmd_if.cmd_valid = 1'b0;

        for (int i = 0; i < steps; i++) begin
            ser_in = sbits[i];
            check("exec_ser_out", ser_out, exp_so.pop_front());
            check("exec_mode", dbg_mode, exp_mode);
            check("exec_busy", busy, 1);
            check("exec_done", done, 0);
            check("exec_ready", cmd_if.cmd_ready, 0);
            tick();
            check("step_q", q, exp_q.pop_front());
        end
        model_q = cur;

        check("done_pulse", done, 1);
        check("done_mode", dbg_mode, 2'b00);
        check("done_ser_out", ser_out, 0);
        check("done_q", q, model_q);
        tick();
        check("after_done", done, 0);
        check("after_ready", cmd_if.cmd_ready, 1);
        check("hold_q", q, model_q);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [2:0]    op;
        logic [CW-1:0] cnt;
        logic [W-1:0]  data;
        logic [7:0]    sbits;
        logic [W-1:0]  exp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 3'd0;
        cmd_if.cmd_cnt   = '0;
        cmd_if.cmd_data  = '0;
        model_q = '0;

        tbl[0]  = '{3'd1, 3'd0, 4'b1011, 8'h00, 4'b1011};
        tbl[1]  = '{3'd2, 3'd2, 4'b0000, 8'h01, 4'b0110};
        tbl[2]  = '{3'd1, 3'd0, 4'b1001, 8'h00, 4'b1001};
        tbl[3]  = '{3'd5, 3'd5, 4'b0000, 8'h00, 4'b0011};
        tbl[4]  = '{3'd3, 3'd0, 4'b1111, 8'hff, 4'b0011};
        tbl[5]  = '{3'd7, 3'd3, 4'b1111, 8'hff, 4'b0011};
        tbl[6]  = '{3'd0, 3'd2, 4'b1111, 8'hff, 4'b0011};
        tbl[7]  = '{3'd4, 3'd3, 4'b0000, 8'h00, 4'b0110};
        tbl[8]  = '{3'd3, 3'd3, 4'b0000, 8'h05, 4'b0101};
        tbl[9]  = '{3'd6, 3'd0, 4'b1111, 8'h00, 4'b0000};
        tbl[10] = '{3'd2, 3'd7, 4'b0000, 8'hff, 4'b1111};
        tbl[11] = '{3'd1, 3'd0, 4'b0110, 8'h00, 4'b0110};
        tbl[12] = '{3'd4, 3'd4, 4'b0000, 8'h00, 4'b0110};
        tbl[13] = '{3'd5, 3'd6, 4'b0000, 8'h00, 4'b1001};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", q, 0);
        check("rst_ready", cmd_if.cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ser_out", ser_out, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            run_cmd(tbl[i].op, tbl[i].cnt, tbl[i].data, tbl[i].sbits);
            check("tbl_final_q", q, tbl[i].exp);
        end

        // cmd_valid held high across a 3-step SHR
        run_cmd(3'd1, 3'd0, 4'b1010, 8'h00);
        ser_in           = 1'b0;
        cmd_if.cmd_op    = 3'd2;
        cmd_if.cmd_cnt   = 3'd3;
        cmd_if.cmd_data  = 4'b0000;
        cmd_if.cmd_valid = 1'b1;
        tick();
        cmd_if.cmd_op   = 3'd1;
        cmd_if.cmd_data = 4'b0101;
        for (int j = 0; j < 4; j++) begin
            check("held_ready_low", cmd_if.cmd_ready, 0);
            tick();
        end
        check("held_shr_q", q, 4'b0001);
        check("held_ready_back", cmd_if.cmd_ready, 1);
        tick();
        cmd_if.cmd_valid = 1'b0;
        check("held_second_exec", dbg_state, ST_EXEC);
        tick();
        check("held_load_q", q, 4'b0101);
        check("held_load_done", done, 1);
        tick();
        model_q = 4'b0101;

        // Reset in the middle of a 3-step ROR
        run_cmd(3'd1, 3'd0, 4'b1001, 8'h00);
        cmd_if.cmd_op    = 3'd4;
        cmd_if.cmd_cnt   = 3'd3;
        cmd_if.cmd_valid = 1'b1;
        tick();
        cmd_if.cmd_valid = 1'b0;
        tick();
        check("ror_step1_q", q, 4'b1100);
        rst_n = 1'b0;
        #1;
        check("midrst_q", q, 0);
        check("midrst_ready", cmd_if.cmd_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_ser_out", ser_out, 0);
        for (int j = 0; j < 3; j++) begin
            tick();
            check("midrst_no_done", done, 0);
        end
        rst_n   = 1'b1;
        model_q = '0;
        tick();
        check("postrst_done", done, 0);
        run_cmd(3'd1, 3'd0, 4'b0110, 8'h00);
        check("postrst_load_q", q, 4'b0110);

        // Random commands against the model
        for (int i = 0; i < 40; i++) begin
            run_cmd(3'($urandom_range(0, 7)), CW'($urandom_range(0, 7)),
                    W'($urandom), 8'($urandom));
            check("rand_final_q", q, model_q);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Command-driven sequencer for a WIDTH-bit universal shift register. It accepts one command at a time over a valid/ready handshake and drives the register's mode selects and serial inputs for the required number of cycles. It reports completion with a one-cycle done pulse. It sits between a host or bus-side requester and the shift datapath, and replaces direct, hand-driven s1/s0/x/y control.

## Interface
- WIDTH, 4: register width in bits; ≥2.
- CNT_W, $clog2(WIDTH)+1: width of the shift-count field.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command; high only in IDLE.
- cmd_op  in  3  opcode:
  - 0 NOP, 1 LOAD, 2 SHR, 3 SHL, 4 ROR, 5 ROL, 6 CLR.
  - 7 is reserved and is treated as NOP.
- cmd_cnt  in  CNT_W  number of shift steps (SHR/SHL/ROR/ROL only).
- cmd_data  in  WIDTH  parallel load value (LOAD only).
- ser_in  in  1  serial input for SHR (enters MSB) and SHL (enters LSB); sampled every shift cycle.
- q  out  WIDTH  register contents.
- ser_out  out  1  bit leaving the register on the current shift cycle; 0 outside EXEC.
- busy  out  1  high in EXEC and DONE.
- done  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - cmd_ready=1.
  - When cmd_valid&&cmd_ready, latch op/cnt/data.
  - Next state is EXEC, or DONE directly if the op is NOP/reserved, or the op is a shift with cnt=0.
- EXEC: one register update per cycle, driven through the core's mode select.
  - LOAD: mode 11 with cmd_data; one cycle.
  - CLR: mode 11 with zeros; one cycle.
  - SHR: mode 01, MSB←ser_in, ser_out=q[0].
  - SHL: mode 10, LSB←ser_in, ser_out=q[WIDTH-1].
  - ROR: mode 01, MSB←q[0], ser_out=q[0].
  - ROL: mode 10, LSB←q[WIDTH-1], ser_out=q[WIDTH-1].
  - The step counter decrements each EXEC cycle. EXEC→DONE on the cycle the last step is applied.
- DONE: done=1 for exactly one cycle, then IDLE. q is held (mode 00).
- Outside EXEC the core mode is 00 (hold).
- Counts larger than WIDTH are legal:
  - Rotates wrap modulo WIDTH.
  - SHR/SHL simply shift ser_in in for every step.
- cmd_valid while busy: ignored (cmd_ready=0). The requester must hold the command until the handshake completes.
- Reset values (any time rst_n=0, asynchronously): q=0, state=IDLE, counter=0, done=0, busy=0, ser_out=0, cmd_ready=1. Any in-flight command is discarded with no done pulse.

## Timing
- Handshake at rising edge k.
- Shift op with cnt=n≥1:
  - q reflects step i after edge k+i.
  - done=1 in the cycle after edge k+n.
  - cmd_ready=1 again after edge k+n+1.
- LOAD/CLR: q updated at edge k+1; done in cycle k+1..k+2; cmd_ready at k+2.
- NOP, reserved op, or cnt=0: done in cycle k..k+1; q unchanged; cmd_ready at k+1.
- Back-to-back throughput: minimum n+2 cycles per shift command.
- ser_out and the core mode are combinational from state and latched op, and are stable for the whole EXEC cycle.
- ser_in is sampled at the edge that ends each EXEC cycle.

## Structure
- Package shift_seq_pkg holds:
  - the op enum (NOP..CLR, RSVD);
  - the state enum (IDLE/EXEC/DONE);
  - the mode constants (HOLD=00, RIGHT=01, LEFT=10, LOAD=11).
- Sub-module shift_reg_core:
  - Parameterised WIDTH universal shift register with mode[1:0], ser_r (into MSB), ser_l (into LSB), pin, q, and async active-low clear.
  - Per-bit 4:1 select with the same encoding as the mode constants.
- The controller contains the FSM, the step counter, the command latch and the serial-input routing.

## Test plan
- Reset then LOAD 4'b1011 → q=1011 after edge k+1; done pulses once; q holds afterwards.
- LOAD 1011, then SHR cnt=2 with ser_in=1,0 → ser_out=1,1; q=1101 then 0110; done in cycle after k+2.
- LOAD 1001, then ROL cnt=5 → q=0011,0110,1100,1001,0011; final q=0011 (wrap modulo 4).
- SHL cnt=0 and op=7 → done in cycle k..k+1; q unchanged; no mode≠00 cycle.
- cmd_valid held high during a 3-step SHR → second command accepted only after DONE; its execution starts at the handshake edge.
- rst_n asserted mid-ROR (after step 1 of 3) → q=0 immediately; no done; cmd_ready=1; a new LOAD after deassertion executes normally.
